// File: rtl/joypad_ctrl_mp.sv
`default_nettype none
// ============================================================================
//  Module      : joypad_ctrl_mp
//  Description : NES-style controller port block with optional four-player
//                multitap. Builds 8-bit per-pad reports (with turbo A/B and
//                opposing-direction masking), latches them while the strobe
//                bit at 0x4016 is high, then shifts one bit out of the
//                addressed port per CPU read of 0x4016 / 0x4017.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    i_clk        in   1            system clock
//    i_rstn       in   1            asynchronous active-low reset
//    i_jpd        in   10*N_PLAYERS pad vectors, player p at [10p+9:10p],
//                                   {up,down,left,right,b,a,tb,ta,select,start}
//    i_turbo_en   in   1            global turbo enable
//    i_bus_acc    in   1            one-cycle valid bus access pulse
//    i_bus_addr   in   16           CPU address
//    i_bus_wn     in   1            0 = write, 1 = read
//    i_bus_wdata  in   8            write data (bit 0 is the strobe)
//    o_jpd_rdata  out  8            read data, only bit 0 is ever non-zero
// ============================================================================
module joypad_ctrl_mp #(
    parameter int N_PLAYERS = 2,
    parameter int TURBO_W   = 16,
    parameter int DPAD_MASK = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic [10*N_PLAYERS-1:0] i_jpd,
    input  logic                    i_turbo_en,
    input  logic                    i_bus_acc,
    input  logic [15:0]             i_bus_addr,
    input  logic                    i_bus_wn,
    input  logic [7:0]              i_bus_wdata,
    output logic [7:0]              o_jpd_rdata
);

    // Report length per port: one pad, or two pads plus a signature byte.
    localparam logic [4:0] c_RPT_LEN = (N_PLAYERS == 4) ? 5'd24 : 5'd8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STROBE = 2'd1,
        S_SHIFT  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [TURBO_W-1:0]  r_turbo_cnt;
    logic [23:0]         r_sr1;
    logic [23:0]         r_sr2;
    logic [4:0]          r_cnt1;
    logic [4:0]          r_cnt2;

    logic                w_turbo;
    logic [7:0]          w_rpt [N_PLAYERS];
    logic [23:0]         w_load1;
    logic [23:0]         w_load2;
    logic                w_sel1;
    logic                w_sel2;
    logic                w_rd1;
    logic                w_rd2;
    logic                w_wr_strb;
    logic                w_bit1;
    logic                w_bit2;
    logic                w_rbit;
    logic                w_unused;

    // Only the strobe bit of the written byte is meaningful.
    assign w_unused = &{1'b0, i_bus_wdata[7:1]};

    // ------------------------------------------------------------------
    // Per-pad report: {right,left,down,up,start,select,B,A}
    // ------------------------------------------------------------------
    function automatic logic [7:0] f_report(input logic [9:0] pad,
                                            input logic       tbit,
                                            input logic       ten);
        logic up, down, left, right, eff_a, eff_b;
        up    = pad[9];
        down  = pad[8];
        left  = pad[7];
        right = pad[6];
        eff_a = (pad[2] && ten) ? tbit : pad[4];
        eff_b = (pad[3] && ten) ? tbit : pad[5];
        if (DPAD_MASK != 0) begin
            // A worn pad can report both opposing directions; games
            // misbehave on that, so treat the pair as released.
            if (up && down) begin
                up   = 1'b0;
                down = 1'b0;
            end
            if (left && right) begin
                left  = 1'b0;
                right = 1'b0;
            end
        end
        return {right, left, down, up, pad[0], pad[1], eff_b, eff_a};
    endfunction

    assign w_turbo = r_turbo_cnt[TURBO_W-1];

    generate
        for (genvar gi = 0; gi < N_PLAYERS; gi++) begin : g_player
            assign w_rpt[gi] = f_report(i_jpd[10*gi +: 10], w_turbo, i_turbo_en);
        end
    endgenerate

    generate
        if (N_PLAYERS == 4) begin : g_multitap
            // Port 1 carries P1, P3, then the 0x10 signature; port 2 carries
            // P2, P4, then 0x20. First bit out is the LSB.
            assign w_load1 = {8'h10, w_rpt[2], w_rpt[0]};
            assign w_load2 = {8'h20, w_rpt[3], w_rpt[1]};
        end else begin : g_single
            assign w_load1 = {16'h0000, w_rpt[0]};
            assign w_load2 = {16'h0000, w_rpt[1]};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    assign w_sel1    = (i_bus_addr == 16'h4016);
    assign w_sel2    = (i_bus_addr == 16'h4017);
    assign w_rd1     = i_bus_acc &  i_bus_wn & w_sel1;
    assign w_rd2     = i_bus_acc &  i_bus_wn & w_sel2;
    // Writes to 0x4017 belong to the APU frame counter and are ignored.
    assign w_wr_strb = i_bus_acc & ~i_bus_wn & w_sel1;

    // ------------------------------------------------------------------
    // Strobe FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_wr_strb) begin
            if (i_bus_wdata[0]) begin
                w_state_nxt = S_STROBE;
            end else if (r_state == S_STROBE) begin
                w_state_nxt = S_SHIFT;
            end
        end
    end

    // ------------------------------------------------------------------
    // Turbo counter
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_turbo_cnt <= '0;
        end else begin
            r_turbo_cnt <= r_turbo_cnt + {{(TURBO_W-1){1'b0}}, 1'b1};
        end
    end

    // ------------------------------------------------------------------
    // Port shift registers and bit counters
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_sr1  <= '0;
            r_sr2  <= '0;
            r_cnt1 <= '0;
            r_cnt2 <= '0;
        end else if (r_state == S_STROBE) begin
            r_sr1  <= w_load1;
            r_sr2  <= w_load2;
            r_cnt1 <= '0;
            r_cnt2 <= '0;
        end else if (r_state == S_SHIFT) begin
            // Counters stop at the report length; further reads return 1.
            if (w_rd1 && (r_cnt1 < c_RPT_LEN)) begin
                r_sr1  <= {1'b0, r_sr1[23:1]};
                r_cnt1 <= r_cnt1 + 5'd1;
            end
            if (w_rd2 && (r_cnt2 < c_RPT_LEN)) begin
                r_sr2  <= {1'b0, r_sr2[23:1]};
                r_cnt2 <= r_cnt2 + 5'd1;
            end
        end
    end

    assign w_bit1 = (r_cnt1 >= c_RPT_LEN) ? 1'b1 : r_sr1[0];
    assign w_bit2 = (r_cnt2 >= c_RPT_LEN) ? 1'b1 : r_sr2[0];

    // ------------------------------------------------------------------
    // Read data: combinational from the current state
    // ------------------------------------------------------------------
    always_comb begin
        w_rbit = 1'b0;
        case (r_state)
            S_STROBE: begin
                // While strobed, the port shows the live A button.
                if (w_rd1) begin
                    w_rbit = w_rpt[0][0];
                end else if (w_rd2) begin
                    w_rbit = w_rpt[1][0];
                end
            end
            S_SHIFT: begin
                if (w_rd1) begin
                    w_rbit = w_bit1;
                end else if (w_rd2) begin
                    w_rbit = w_bit2;
                end
            end
            default: begin
                w_rbit = 1'b0;
            end
        endcase
    end

    assign o_jpd_rdata = {7'b0000000, w_rbit};

endmodule
`default_nettype wire

// File: doc/joypad_ctrl_mp.md
JOYPAD_CTRL_MP -- requirements
Module: joypad_ctrl_mp

Interface
REQ-001 SHALL have parameter N_PLAYERS, default 2, number of pads (legal values 2 or 4; 4 selects four-player multitap mode).
REQ-002 SHALL have parameter TURBO_W, default 16, turbo counter width; the turbo toggle is counter bit TURBO_W-1.
REQ-003 SHALL have parameter DPAD_MASK, default 1; when 1, opposing directions pressed together (up+down, left+right) are both reported released.
REQ-004 i_clk  input  1  system clock; the block's only clock.
REQ-005 i_rstn  input  1  asynchronous active-low reset.
REQ-006 i_jpd  input  10*N_PLAYERS  pad vectors; player p occupies bits [10p+9:10p], ordered {up,down,left,right,b,a,tb,ta,select,start}, 1 = pressed.
REQ-007 i_turbo_en  input  1  global turbo enable.
REQ-008 i_bus_acc  input  1  one-cycle pulse marking a valid CPU bus access.
REQ-009 i_bus_addr  input  16  CPU address.
REQ-010 i_bus_wn  input  1  0 = write, 1 = read.
REQ-011 i_bus_wdata  input  8  write data.
REQ-012 o_jpd_rdata  output  8  read data; bits 7:1 always 0.

Function
REQ-013 Turbo counter SHALL increment by 1 every cycle and wrap modulo 2^TURBO_W.
REQ-014 Effective A SHALL be the turbo bit when ta=1 and i_turbo_en=1, otherwise a; effective B likewise from tb and b.
REQ-015 Per-player 8-bit report, LSB first: A, B, select, start, up, down, left, right, after DPAD_MASK is applied.
REQ-016 Strobe FSM states: IDLE (reset), STROBE, SHIFT.
REQ-017 A write access (i_bus_acc=1, wn=0) to 0x4016 with wdata[0]=1 SHALL enter STROBE from any state.
REQ-018 In STROBE, both port shift registers SHALL reload every cycle from live inputs, and both bit counters SHALL be held at 0.
REQ-019 A write to 0x4016 with wdata[0]=0 SHALL move STROBE to SHIFT; the same write in IDLE or SHIFT SHALL change nothing.
REQ-020 Port 1 (0x4016) report SHALL be P1 in 2-player mode; in 4-player mode it SHALL be P1, then P3, then signature 0x10, LSB first (24 bits).
REQ-021 Port 2 (0x4017) report SHALL be P2 in 2-player mode; in 4-player mode it SHALL be P2, then P4, then signature 0x20, LSB first (24 bits).
REQ-022 A read access (i_bus_acc=1, wn=1) SHALL return the current port bit 0 combinationally in o_jpd_rdata[0].
REQ-023 In SHIFT, each read access SHALL advance only the addressed port by one bit on the following clock edge; exactly one shift per i_bus_acc pulse, regardless of how long the address is held.
REQ-024 Each port bit counter SHALL saturate at the report length (8 or 24); every read past the end SHALL return 1.
REQ-025 A read in STROBE SHALL return live effective A of P1 (port 1) or P2 (port 2) and SHALL NOT shift.
REQ-026 A read in IDLE SHALL return 0 and SHALL NOT shift.
REQ-027 o_jpd_rdata SHALL be 0x00 when i_bus_acc=0, on writes, and for any address other than 0x4016/0x4017.
REQ-028 A write to 0x4017 SHALL NOT affect this block (APU frame counter owns it).
REQ-029 Ports 1 and 2 SHALL shift independently; reading one SHALL NOT disturb the other.

Reset
REQ-030 While i_rstn=0: FSM in IDLE, turbo counter 0, shift registers 0, bit counters 0, o_jpd_rdata 0x00.
REQ-031 Reset asserted mid-report SHALL abort the report immediately; after release, reads return 0 until a strobe sequence completes.

Verification
REQ-032 2P: P1 holds A+right, write 1 then 0 to 0x4016, then 10 reads of 0x4016 -> 1,0,0,0,0,0,0,1,1,1.
REQ-033 4P: P3=start only, P1 idle, strobe, 26 reads of 0x4016 -> bits 0-7 all 0; bit 11 =1 with bits 8-10 and 12-15 0; bits 16-23 = 0,0,0,0,1,0,0,0; bits 24-25 = 1,1.
REQ-034 Turbo: TURBO_W=4, ta=1, a=0, i_turbo_en=1, strobe held high -> read of 0x4016 toggles every 8 cycles; i_turbo_en=0 -> constant 0.
REQ-035 DPAD_MASK=1, up+down+left pressed -> report bits 4,5 = 0 and bit 6 = 1; with DPAD_MASK=0 bits 4,5,6 = 1.
REQ-036 Address 0x4016 held 5 cycles with one i_bus_acc pulse -> exactly one shift; alternating reads of 0x4016/0x4017 -> each port advances independently.
REQ-037 Reset pulsed after 3 reads -> o_jpd_rdata 0x00, subsequent reads 0 until a new strobe.
